// File: rtl/rsv_station_gen.sv
// Age-ordered ALU reservation station: CDB operand wakeup, oldest-ready issue into a registered valid/ready stage.
// Optional RS_CDB_BYPASS_EN: dispatched operands also capture a same-cycle CDB broadcast.
module rsv_station_gen #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4,
    parameter int OP_W   = 6,
    parameter int NCDB   = 2,
    localparam int OCC_W = $clog2(DEPTH + 1),
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [OP_W-1:0]        in_op,
    input  logic [DATA_W-1:0]      in_pc,
    input  logic [DATA_W-1:0]      in_imm,
    input  logic [TAG_W-1:0]       in_rob_id,
    input  logic                   in_rs1_rdy,
    input  logic [DATA_W-1:0]      in_rs1_val,
    input  logic [TAG_W-1:0]       in_rs1_tag,
    input  logic                   in_rs2_rdy,
    input  logic [DATA_W-1:0]      in_rs2_val,
    input  logic [TAG_W-1:0]       in_rs2_tag,
    input  logic [NCDB-1:0]        cdb_valid,
    input  logic [NCDB*TAG_W-1:0]  cdb_tag,
    input  logic [NCDB*DATA_W-1:0] cdb_val,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OP_W-1:0]        out_op,
    output logic [DATA_W-1:0]      out_pc,
    output logic [DATA_W-1:0]      out_rs1,
    output logic [DATA_W-1:0]      out_rs2,
    output logic [DATA_W-1:0]      out_imm,
    output logic [TAG_W-1:0]       out_rob_id,
    output logic [OCC_W-1:0]       occupancy
);

    logic [DEPTH-1:0]  busy;
    logic [OP_W-1:0]   e_op      [DEPTH];
    logic [DATA_W-1:0] e_pc      [DEPTH];
    logic [DATA_W-1:0] e_imm     [DEPTH];
    logic [TAG_W-1:0]  e_rob     [DEPTH];
    logic [DEPTH-1:0]  e_rs1_rdy;
    logic [DATA_W-1:0] e_rs1_val [DEPTH];
    logic [TAG_W-1:0]  e_rs1_tag [DEPTH];
    logic [DEPTH-1:0]  e_rs2_rdy;
    logic [DATA_W-1:0] e_rs2_val [DEPTH];
    logic [TAG_W-1:0]  e_rs2_tag [DEPTH];
    // older[i][j] set means entry j was dispatched before entry i.
    logic [DEPTH-1:0]  older     [DEPTH];

    logic [TAG_W-1:0]  c_tag [NCDB];
    logic [DATA_W-1:0] c_val [NCDB];

    for (genvar k = 0; k < NCDB; k++) begin : g_cdb
        assign c_tag[k] = cdb_tag[k*TAG_W +: TAG_W];
        assign c_val[k] = cdb_val[k*DATA_W +: DATA_W];
    end

    logic [DEPTH-1:0]  w_rs1_rdy, w_rs2_rdy;
    logic [DATA_W-1:0] w_rs1_val [DEPTH];
    logic [DATA_W-1:0] w_rs2_val [DEPTH];

    // Walking channels high to low lets the lowest matching channel win.
    // NOTE: combinational blocks use blocking assignments and give every output a default first, so no latch can be inferred.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_rs1_rdy[i] = e_rs1_rdy[i];
            w_rs1_val[i] = e_rs1_val[i];
            w_rs2_rdy[i] = e_rs2_rdy[i];
            w_rs2_val[i] = e_rs2_val[i];
            for (int k = NCDB - 1; k >= 0; k--) begin
                if (!e_rs1_rdy[i] && cdb_valid[k] && (c_tag[k] == e_rs1_tag[i])) begin
                    w_rs1_rdy[i] = 1'b1;
                    w_rs1_val[i] = c_val[k];
                end
                if (!e_rs2_rdy[i] && cdb_valid[k] && (c_tag[k] == e_rs2_tag[i])) begin
                    w_rs2_rdy[i] = 1'b1;
                    w_rs2_val[i] = c_val[k];
                end
            end
        end
    end

    logic              n_rs1_rdy, n_rs2_rdy;
    logic [DATA_W-1:0] n_rs1_val, n_rs2_val;

`ifdef RS_CDB_BYPASS_EN
    always_comb begin
        n_rs1_rdy = in_rs1_rdy;
        n_rs1_val = in_rs1_val;
        n_rs2_rdy = in_rs2_rdy;
        n_rs2_val = in_rs2_val;
        for (int k = NCDB - 1; k >= 0; k--) begin
            if (!in_rs1_rdy && cdb_valid[k] && (c_tag[k] == in_rs1_tag)) begin
                n_rs1_rdy = 1'b1;
                n_rs1_val = c_val[k];
            end
            if (!in_rs2_rdy && cdb_valid[k] && (c_tag[k] == in_rs2_tag)) begin
                n_rs2_rdy = 1'b1;
                n_rs2_val = c_val[k];
            end
        end
    end
`else
    assign n_rs1_rdy = in_rs1_rdy;
    assign n_rs1_val = in_rs1_val;
    assign n_rs2_rdy = in_rs2_rdy;
    assign n_rs2_val = in_rs2_val;
`endif

    logic [DEPTH-1:0] cand, sel, issue_mask;
    logic [IDX_W-1:0] sel_idx, alloc_idx;
    logic             issue_en, issue_hit, alloc_en;

    assign cand = busy & e_rs1_rdy & e_rs2_rdy;

    always_comb begin
        sel       = '0;
        sel_idx   = '0;
        alloc_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            sel[i] = cand[i] && ((older[i] & cand) == '0);
            if (sel[i])   sel_idx   = IDX_W'(i);
            if (!busy[i]) alloc_idx = IDX_W'(i);
        end
    end

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) occupancy = occupancy + OCC_W'(busy[i]);
    end

    assign in_ready   = (occupancy < OCC_W'(DEPTH));
    assign issue_en   = rdy && !flush && (!out_valid || out_ready);
    assign issue_hit  = issue_en && (cand != '0);
    assign alloc_en   = rdy && !flush && in_valid && in_ready;
    assign issue_mask = issue_hit ? sel : '0;

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy       <= '0;
            out_valid  <= 1'b0;
            out_op     <= '0;
            out_pc     <= '0;
            out_rs1    <= '0;
            out_rs2    <= '0;
            out_imm    <= '0;
            out_rob_id <= '0;
        end else if (rdy) begin
            if (flush) begin
                busy      <= '0;
                out_valid <= 1'b0;
            end else begin
                if (issue_en) begin
                    out_valid <= issue_hit;
                    if (issue_hit) begin
                        out_op        <= e_op[sel_idx];
                        out_pc        <= e_pc[sel_idx];
                        out_rs1       <= e_rs1_val[sel_idx];
                        out_rs2       <= e_rs2_val[sel_idx];
                        out_imm       <= e_imm[sel_idx];
                        out_rob_id    <= e_rob[sel_idx];
                        busy[sel_idx] <= 1'b0;
                    end
                end
                if (alloc_en) busy[alloc_idx] <= 1'b1;
            end
        end
    end

    // NOTE: entry payload and age matrix have no reset; busy qualifies every use, and allocation rewrites them.
    always_ff @(posedge clk) begin
        if (rdy && !flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (busy[i]) begin
                    e_rs1_rdy[i] <= w_rs1_rdy[i];
                    e_rs1_val[i] <= w_rs1_val[i];
                    e_rs2_rdy[i] <= w_rs2_rdy[i];
                    e_rs2_val[i] <= w_rs2_val[i];
                end
                if (alloc_en) older[i][alloc_idx] <= 1'b0;
            end
            if (alloc_en) begin
                e_op[alloc_idx]      <= in_op;
                e_pc[alloc_idx]      <= in_pc;
                e_imm[alloc_idx]     <= in_imm;
                e_rob[alloc_idx]     <= in_rob_id;
                e_rs1_rdy[alloc_idx] <= n_rs1_rdy;
                e_rs1_val[alloc_idx] <= n_rs1_val;
                e_rs1_tag[alloc_idx] <= in_rs1_tag;
                e_rs2_rdy[alloc_idx] <= n_rs2_rdy;
                e_rs2_val[alloc_idx] <= n_rs2_val;
                e_rs2_tag[alloc_idx] <= in_rs2_tag;
                older[alloc_idx]     <= busy & ~issue_mask;
            end
        end
    end

endmodule

// File: tb/tb_rsv_station_gen.sv
// Directed bench for rsv_station_gen with default parameters; expectations follow RS_CDB_BYPASS_EN when defined.
module tb_rsv_station_gen;

    logic        clk = 1'b0;
    logic        rst, rdy, flush;
    logic        in_valid, in_ready;
    logic [5:0]  in_op;
    logic [31:0] in_pc, in_imm;
    logic [3:0]  in_rob_id;
    logic        in_rs1_rdy, in_rs2_rdy;
    logic [31:0] in_rs1_val, in_rs2_val;
    logic [3:0]  in_rs1_tag, in_rs2_tag;
    logic [1:0]  cdb_valid;
    logic [7:0]  cdb_tag;
    logic [63:0] cdb_val;
    logic        out_valid, out_ready;
    logic [5:0]  out_op;
    logic [31:0] out_pc, out_rs1, out_rs2, out_imm;
    logic [3:0]  out_rob_id;
    logic [4:0]  occupancy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rsv_station_gen dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_pc(in_pc),
        .in_imm(in_imm), .in_rob_id(in_rob_id),
        .in_rs1_rdy(in_rs1_rdy), .in_rs1_val(in_rs1_val), .in_rs1_tag(in_rs1_tag),
        .in_rs2_rdy(in_rs2_rdy), .in_rs2_val(in_rs2_val), .in_rs2_tag(in_rs2_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_pc(out_pc),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
        .out_rob_id(out_rob_id), .occupancy(occupancy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cdb(input int k, input logic [3:0] tag, input logic [31:0] val);
        cdb_valid[k]         = 1'b1;
        cdb_tag[k*4 +: 4]    = tag;
        cdb_val[k*32 +: 32]  = val;
    endtask

    task automatic dispatch(input logic [5:0] op, input logic [3:0] rob,
                            input logic r1rdy, input logic [31:0] r1val, input logic [3:0] r1tag,
                            input logic r2rdy, input logic [31:0] r2val, input logic [3:0] r2tag);
        in_valid   = 1'b1;
        in_op      = op;
        in_rob_id  = rob;
        in_pc      = 32'h100 + {28'd0, rob};
        in_imm     = 32'hA0 + {28'd0, rob};
        in_rs1_rdy = r1rdy; in_rs1_val = r1val; in_rs1_tag = r1tag;
        in_rs2_rdy = r2rdy; in_rs2_val = r2val; in_rs2_tag = r2tag;
        tick();
        in_valid   = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        if (out_valid !== 1'b0) begin $display("FAIL reset_out_valid: got %b want 0", out_valid); bad++; end
        total++;
        if (out_rs1 !== 32'd0 || out_op !== 6'd0 || out_rob_id !== 4'd0) begin
            $display("FAIL reset_payload: got rs1=%h op=%h rob=%h want 0", out_rs1, out_op, out_rob_id); bad++;
        end
        total++;
        if (occupancy !== 5'd0) begin $display("FAIL reset_occupancy: got %0d want 0", occupancy); bad++; end
        total++;
        if (in_ready !== 1'b1) begin $display("FAIL reset_in_ready: got %b want 1", in_ready); bad++; end
        total++;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        dispatch(6'd3, 4'd2, 1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0);
        if (occupancy !== 5'd1 || out_valid !== 1'b0) begin
            $display("FAIL basic_alloc: got occ=%0d valid=%b want occ=1 valid=0", occupancy, out_valid); bad++;
        end
        total++;
        tick();
        if (out_valid !== 1'b1 || out_op !== 6'd3 || out_rs1 !== 32'd5 || out_rs2 !== 32'd7 || out_rob_id !== 4'd2) begin
            $display("FAIL basic_issue: got v=%b op=%0d rs1=%h rs2=%h rob=%0d want 1/3/5/7/2",
                     out_valid, out_op, out_rs1, out_rs2, out_rob_id); bad++;
        end
        total++;
        if (out_pc !== 32'h102 || out_imm !== 32'hA2 || occupancy !== 5'd0) begin
            $display("FAIL basic_pc_imm_occ: got pc=%h imm=%h occ=%0d want 102/a2/0", out_pc, out_imm, occupancy); bad++;
        end
        total++;
        tick();
        if (out_valid !== 1'b0) begin $display("FAIL basic_drain: got %b want 0", out_valid); bad++; end
        total++;
    endtask

    task automatic test_wakeup();
        out_ready = 1'b1;
        dispatch(6'd1, 4'd1, 1'b0, 32'd0, 4'd4, 1'b1, 32'd1, 4'd0);
        dispatch(6'd2, 4'd3, 1'b1, 32'h10, 4'd0, 1'b1, 32'h20, 4'd0);
        if (occupancy !== 5'd2 || out_valid !== 1'b0) begin
            $display("FAIL wake_alloc: got occ=%0d valid=%b want 2/0", occupancy, out_valid); bad++;
        end
        total++;
        tick();
        if (out_valid !== 1'b1 || out_rob_id !== 4'd3) begin
            $display("FAIL wake_ready_first: got v=%b rob=%0d want 1/3", out_valid, out_rob_id); bad++;
        end
        total++;
        set_cdb(0, 4'd4, 32'h99);
        set_cdb(1, 4'd4, 32'h55);
        tick();
        cdb_valid = '0;
        if (out_valid !== 1'b0) begin $display("FAIL wake_gap: got %b want 0", out_valid); bad++; end
        total++;
        tick();
        if (out_valid !== 1'b1 || out_rob_id !== 4'd1 || out_rs1 !== 32'h99) begin
            $display("FAIL wake_issue: got v=%b rob=%0d rs1=%h want 1/1/99", out_valid, out_rob_id, out_rs1); bad++;
        end
        total++;
        tick();
    endtask

    task automatic test_age();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++)
            dispatch(6'd5, 4'(8 + i), 1'b0, 32'd0, 4'(8 + i), 1'b1, 32'd0, 4'd0);
        dispatch(6'd6, 4'd5, 1'b0, 32'd0, 4'd7, 1'b1, 32'hA, 4'd0);
        set_cdb(0, 4'd9, 32'h9);
        tick();
        cdb_valid = '0;
        tick();
        if (out_valid !== 1'b1 || out_rob_id !== 4'd9 || occupancy !== 5'd5) begin
            $display("FAIL age_free_slot: got v=%b rob=%0d occ=%0d want 1/9/5", out_valid, out_rob_id, occupancy); bad++;
        end
        total++;
        dispatch(6'd6, 4'd6, 1'b0, 32'd0, 4'd7, 1'b1, 32'hB, 4'd0);
        set_cdb(0, 4'd7, 32'h77);
        tick();
        cdb_valid = '0;
        tick();
        if (out_valid !== 1'b1 || out_rob_id !== 4'd5 || out_rs1 !== 32'h77) begin
            $display("FAIL age_older_first: got v=%b rob=%0d rs1=%h want 1/5/77", out_valid, out_rob_id, out_rs1); bad++;
        end
        total++;
        tick();
        if (out_valid !== 1'b1 || out_rob_id !== 4'd6 || out_rs2 !== 32'hB) begin
            $display("FAIL age_younger_next: got v=%b rob=%0d rs2=%h want 1/6/b", out_valid, out_rob_id, out_rs2); bad++;
        end
        total++;
        do_flush();
    endtask

    task automatic test_full();
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++)
            dispatch(6'd4, 4'(i), 1'b0, 32'd0, 4'(i), 1'b1, 32'd0, 4'd0);
        if (occupancy !== 5'd16 || in_ready !== 1'b0) begin
            $display("FAIL full_state: got occ=%0d rdy=%b want 16/0", occupancy, in_ready); bad++;
        end
        total++;
        in_valid = 1'b1;
        in_rob_id = 4'd15; in_rs1_rdy = 1'b1; in_rs2_rdy = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        if (occupancy !== 5'd16 || out_valid !== 1'b0) begin
            $display("FAIL full_ignore: got occ=%0d v=%b want 16/0", occupancy, out_valid); bad++;
        end
        total++;
        set_cdb(0, 4'd3, 32'h33);
        tick();
        cdb_valid = '0;
        tick();
        if (out_valid !== 1'b1 || out_rob_id !== 4'd3 || out_rs1 !== 32'h33) begin
            $display("FAIL full_issue: got v=%b rob=%0d rs1=%h want 1/3/33", out_valid, out_rob_id, out_rs1); bad++;
        end
        total++;
        if (occupancy !== 5'd15 || in_ready !== 1'b1) begin
            $display("FAIL full_release: got occ=%0d rdy=%b want 15/1", occupancy, in_ready); bad++;
        end
        total++;
        do_flush();
    endtask

    task automatic test_stall_flush();
        out_ready = 1'b0;
        dispatch(6'd9, 4'd9, 1'b1, 32'hAA, 4'd0, 1'b1, 32'hBB, 4'd0);
        dispatch(6'd10, 4'd10, 1'b1, 32'hCC, 4'd0, 1'b1, 32'hDD, 4'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            if (out_valid !== 1'b1 || out_rob_id !== 4'd9 || out_rs1 !== 32'hAA || out_rs2 !== 32'hBB || occupancy !== 5'd1) begin
                $display("FAIL stall_hold%0d: got v=%b rob=%0d rs1=%h rs2=%h occ=%0d want 1/9/aa/bb/1",
                         c, out_valid, out_rob_id, out_rs1, out_rs2, occupancy); bad++;
            end
            total++;
        end
        rdy = 1'b0;
        out_ready = 1'b1;
        tick();
        if (out_valid !== 1'b1 || out_rob_id !== 4'd9 || occupancy !== 5'd1) begin
            $display("FAIL freeze: got v=%b rob=%0d occ=%0d want 1/9/1", out_valid, out_rob_id, occupancy); bad++;
        end
        total++;
        rdy = 1'b1;
        do_flush();
        if (out_valid !== 1'b0 || occupancy !== 5'd0 || in_ready !== 1'b1) begin
            $display("FAIL flush: got v=%b occ=%0d rdy=%b want 0/0/1", out_valid, occupancy, in_ready); bad++;
        end
        total++;
    endtask

    task automatic test_bypass();
        out_ready = 1'b1;
        set_cdb(1, 4'd6, 32'h1234);
        dispatch(6'd7, 4'd4, 1'b1, 32'd1, 4'd0, 1'b0, 32'd0, 4'd6);
        cdb_valid = '0;
`ifdef RS_CDB_BYPASS_EN
        tick();
        if (out_valid !== 1'b1 || out_rs2 !== 32'h1234 || out_rob_id !== 4'd4) begin
            $display("FAIL bypass_issue: got v=%b rs2=%h rob=%0d want 1/1234/4", out_valid, out_rs2, out_rob_id); bad++;
        end
        total++;
`else
        for (int c = 0; c < 4; c++) tick();
        if (out_valid !== 1'b0 || occupancy !== 5'd1) begin
            $display("FAIL no_bypass_stuck: got v=%b occ=%0d want 0/1", out_valid, occupancy); bad++;
        end
        total++;
`endif
        do_flush();
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0;
        dispatch(6'd11, 4'd11, 1'b1, 32'h11, 4'd0, 1'b1, 32'h12, 4'd0);
        dispatch(6'd12, 4'd12, 1'b1, 32'h21, 4'd0, 1'b1, 32'h22, 4'd0);
        if (out_valid !== 1'b1 || out_rob_id !== 4'd11) begin
            $display("FAIL midrst_setup: got v=%b rob=%0d want 1/11", out_valid, out_rob_id); bad++;
        end
        total++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        if (out_valid !== 1'b0 || out_rs1 !== 32'd0 || out_op !== 6'd0 || occupancy !== 5'd0 || in_ready !== 1'b1) begin
            $display("FAIL midrst_clear: got v=%b rs1=%h op=%0d occ=%0d rdy=%b want 0/0/0/0/1",
                     out_valid, out_rs1, out_op, occupancy, in_ready); bad++;
        end
        total++;
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_op = '0; in_pc = '0; in_imm = '0; in_rob_id = '0;
        in_rs1_rdy = 1'b0; in_rs1_val = '0; in_rs1_tag = '0;
        in_rs2_rdy = 1'b0; in_rs2_val = '0; in_rs2_tag = '0;
        cdb_valid = '0; cdb_tag = '0; cdb_val = '0;
        test_reset();
        test_basic();
        test_wakeup();
        test_age();
        test_full();
        test_stall_flush();
        test_bypass();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rsv_station_gen.md
# rsv_station_gen

Parametrised, age-ordered reservation station between Decoder/RegFile and the ALU. It holds up to DEPTH dispatched ALU instructions and wakes their operands from NCDB parallel result broadcasts (ROB/CDB). It issues the oldest ready entry to the ALU through a registered valid/ready output stage. Flush and stall handling are built in for speculative recovery.

## Interface
- DEPTH, 16: entry count, ≥2.
- DATA_W, 32: operand, PC and immediate width.
- TAG_W, 4: ROB id width.
- OP_W, 6: opcode id width.
- NCDB, 2: number of broadcast channels, ≥1.
- clk  in  1  clock.
- rst  in  1  reset: rst, synchronous, active-high; clock clk.
- rdy  in  1  global enable; low freezes all state.
- flush  in  1  mispredict recovery; discards all entries.
- in_valid  in  1  dispatch request.
- in_ready  out  1  at least one free entry.
- in_op  in  OP_W  opcode id.
- in_pc  in  DATA_W  instruction PC.
- in_imm  in  DATA_W  immediate.
- in_rob_id  in  TAG_W  destination ROB id.
- in_rs1_rdy / in_rs2_rdy  in  1  operand value present (or operand unused).
- in_rs1_val / in_rs2_val  in  DATA_W  operand value.
- in_rs1_tag / in_rs2_tag  in  TAG_W  producer ROB id when not ready.
- cdb_valid  in  NCDB  per-channel broadcast valid.
- cdb_tag  in  NCDB*TAG_W  packed tags; channel k in bits [k*TAG_W +: TAG_W].
- cdb_val  in  NCDB*DATA_W  packed values, same packing.
- out_valid  out  1  issue valid.
- out_ready  in  1  ALU accepts.
- out_op, out_pc, out_rs1, out_rs2, out_imm, out_rob_id  out  widths as inputs  issued payload.
- occupancy  out  $clog2(DEPTH+1)  live entry count.

## Operation
- Per-entry state: busy, payload, per-operand rdy/val/tag, and an age row older[j].
- Allocation: in_valid && in_ready writes the lowest-index free entry. older[] := current busy mask, minus any entry issuing this cycle.
- Wakeup: for each busy entry, each non-ready operand whose tag equals cdb_tag[k] with cdb_valid[k] captures cdb_val[k] and sets rdy. Duplicate tags on two channels: the lower k wins.
- Select: candidate = busy && rs1 rdy && rs2 rdy (registered state only). The chosen entry is the candidate with no older candidate.
- Issue: when !out_valid || out_ready, the selected entry loads the output registers. out_valid becomes 1 and the entry is freed in the same edge. If there is no candidate, out_valid becomes 0.
- Allocation and issue may hit the same edge. in_ready = (occupancy < DEPTH) and does not count the same-cycle issue.
- Flush (when rdy): next edge clears all busy bits, out_valid, and occupancy. Flush has priority over allocation, wakeup and issue.
- rdy low: no state changes. Outputs hold.

## Timing
- Reset values: out_valid 0, every payload output 0, occupancy 0, in_ready 1, all busy 0.
- Minimum dispatch-to-out_valid latency is 1 cycle when both operands arrive ready.
- A CDB wakeup in cycle N makes the entry a candidate in N+1; out_valid is seen in N+2.
- out_valid/payload are stable while out_valid && !out_ready.
- Rst mid-operation equals flush plus output clear.

## Configuration
- RS_CDB_BYPASS_EN defined: the incoming operands at allocation are also compared with the same-cycle CDB. A match stores the CDB value as ready, with the lower k winning.
- RS_CDB_BYPASS_EN undefined: incoming tags are stored as-is. Upstream must forward same-cycle broadcasts itself, otherwise that wakeup is lost.

## Test plan
- Dispatch, both operands ready, op=3, rs1=5, rs2=7, rob=2, out_ready=1: out_valid next cycle with out_rs1=5, out_rs2=7, out_rob_id=2. occupancy returns to 0.
- Dispatch A (rs1 tag 4) then B (ready), hold out_ready=1: B issues first. cdb0 tag 4 val 0x99 → A issues two cycles later with out_rs1=0x99.
- Age order: fill entries so that older A occupies index 5 and younger B index 1, wake both together: A issues before B.
- Fill DEPTH entries with unresolved tags: in_ready=0, occupancy=DEPTH, further in_valid ignored. One broadcast frees one entry after issue; in_ready returns to 1.
- out_ready=0 for 3 cycles with out_valid=1: payload constant. Flush asserted → next cycle out_valid=0, occupancy=0, in_ready=1.
- With RS_CDB_BYPASS_EN: dispatch rs2 tag 6 in the same cycle cdb1 tag 6 val 0x1234 → out_rs2=0x1234 one cycle later. Without the macro, the same stimulus never issues.
